// File: rtl/prach_pkg.sv
// Shared constants and helpers for the PRACH decimation datapath.
package prach_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CHN_W    = 8;

    // Accumulator grows by log2(DECIM) bits so a full block of sums never overflows.
    function automatic int acc_width(input int decim);
        return SAMPLE_W + $clog2(decim);
    endfunction

endpackage

// File: rtl/prach_decim_acc_bank.sv
// Per-channel phase counters and accumulators: single-cycle read-modify-write
// of the addressed channel, with a registered dump of each completed block sum.
module prach_decim_acc_bank
    import prach_pkg::*;
#(
    parameter int NUM_CHN = 8,
    parameter int DECIM   = 4,
    localparam int ACC_W  = acc_width(DECIM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] dr_i,
    input  logic [SAMPLE_W-1:0] di_i,
    input  logic                dv_i,
    input  logic [CHN_W-1:0]    chn_i,
    input  logic                sync_i,
    output logic                dump_o,
    output logic [ACC_W-1:0]    sum_r_o,
    output logic [ACC_W-1:0]    sum_i_o,
    output logic [CHN_W-1:0]    chn_o,
    output logic                err_o
);

    localparam int SHIFT = $clog2(DECIM);
    localparam int IDX_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam logic [CHN_W-1:0] NUM_CHN_L = CHN_W'(NUM_CHN);
    localparam logic [SHIFT-1:0] LAST      = SHIFT'(DECIM - 1);

    logic [SHIFT-1:0] cnt_q   [NUM_CHN];
    logic [ACC_W-1:0] acc_r_q [NUM_CHN];
    logic [ACC_W-1:0] acc_i_q [NUM_CHN];

    logic             dump_q, err_q;
    logic [ACC_W-1:0] sum_r_q, sum_i_q;
    logic [CHN_W-1:0] chn_q;

    logic             in_range, accept;
    logic [IDX_W-1:0] idx;
    logic [SHIFT-1:0] phase;
    logic [ACC_W-1:0] ext_r, ext_i, sum_r_d, sum_i_d;

    // A same-cycle sync makes this sample the first of a fresh block.
    always_comb begin
        in_range = chn_i < NUM_CHN_L;
        accept   = dv_i && in_range;
        idx      = in_range ? chn_i[IDX_W-1:0] : '0;
        phase    = sync_i ? '0 : cnt_q[idx];
        ext_r    = {{SHIFT{dr_i[SAMPLE_W-1]}}, dr_i};
        ext_i    = {{SHIFT{di_i[SAMPLE_W-1]}}, di_i};
        sum_r_d  = (phase == '0) ? ext_r : acc_r_q[idx] + ext_r;
        sum_i_d  = (phase == '0) ? ext_i : acc_i_q[idx] + ext_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '{default: '0};
            acc_r_q <= '{default: '0};
            acc_i_q <= '{default: '0};
            dump_q  <= 1'b0;
            err_q   <= 1'b0;
            sum_r_q <= '0;
            sum_i_q <= '0;
            chn_q   <= '0;
        end else begin
            dump_q <= 1'b0;
            err_q  <= dv_i && !in_range;
            if (sync_i) begin
                cnt_q <= '{default: '0};
            end
            if (accept) begin
                acc_r_q[idx] <= sum_r_d;
                acc_i_q[idx] <= sum_i_d;
                if (phase == LAST) begin
                    cnt_q[idx] <= '0;
                    dump_q     <= 1'b1;
                    sum_r_q    <= sum_r_d;
                    sum_i_q    <= sum_i_d;
                    chn_q      <= chn_i;
                end else begin
                    cnt_q[idx] <= phase + SHIFT'(1);
                end
            end
        end
    end

    assign dump_o  = dump_q;
    assign sum_r_o = sum_r_q;
    assign sum_i_o = sum_i_q;
    assign chn_o   = chn_q;
    assign err_o   = err_q;

endmodule

// File: rtl/prach_delay.sv
// Generic registered delay line with synchronous active-low reset; DEPTH must be >= 2.
module prach_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/prach_decim_acc.sv
// TDM integrate-and-dump decimator: block sums from the bank are rounded to the
// mean (round-half-up) and registered out in the same TDM format as the input.
module prach_decim_acc
    import prach_pkg::*;
#(
    parameter int NUM_CHN = 8,
    parameter int DECIM   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] din_dr,
    input  logic [SAMPLE_W-1:0] din_di,
    input  logic                din_dv,
    input  logic [CHN_W-1:0]    din_chn,
    input  logic                sync_in,
    output logic [SAMPLE_W-1:0] dout_dr,
    output logic [SAMPLE_W-1:0] dout_di,
    output logic                dout_dv,
    output logic [CHN_W-1:0]    dout_chn,
    output logic                sync_out,
    output logic                err_chn
);

    localparam int SHIFT = $clog2(DECIM);
    localparam int ACC_W = acc_width(DECIM);
    localparam logic [ACC_W-1:0] HALF = ACC_W'(2 ** (SHIFT - 1));

    logic             dump;
    logic [ACC_W-1:0] sum_r, sum_i, rnd_r, rnd_i;
    logic [CHN_W-1:0] sum_chn;

    logic [SAMPLE_W-1:0] dout_dr_q, dout_di_q;
    logic [CHN_W-1:0]    dout_chn_q;
    logic                dout_dv_q;

    prach_decim_acc_bank #(
        .NUM_CHN (NUM_CHN),
        .DECIM   (DECIM)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .dr_i    (din_dr),
        .di_i    (din_di),
        .dv_i    (din_dv),
        .chn_i   (din_chn),
        .sync_i  (sync_in),
        .dump_o  (dump),
        .sum_r_o (sum_r),
        .sum_i_o (sum_i),
        .chn_o   (sum_chn),
        .err_o   (err_chn)
    );

    // Taking bits [SHIFT +: 16] of the biased sum is the arithmetic shift truncated to 16 bits.
    always_comb begin
        rnd_r = sum_r + HALF;
        rnd_i = sum_i + HALF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_dr_q  <= '0;
            dout_di_q  <= '0;
            dout_chn_q <= '0;
            dout_dv_q  <= 1'b0;
        end else begin
            dout_dv_q <= dump;
            if (dump) begin
                dout_dr_q  <= rnd_r[SHIFT +: SAMPLE_W];
                dout_di_q  <= rnd_i[SHIFT +: SAMPLE_W];
                dout_chn_q <= sum_chn;
            end
        end
    end

    prach_delay #(
        .WIDTH (1),
        .DEPTH (2)
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sync_in),
        .q_o   (sync_out)
    );

    assign dout_dr  = dout_dr_q;
    assign dout_di  = dout_di_q;
    assign dout_chn = dout_chn_q;
    assign dout_dv  = dout_dv_q;

endmodule

// File: tb/tb_prach_decim_acc.sv
// Scoreboard bench for prach_decim_acc: directed cases plus random TDM traffic.
module tb_prach_decim_acc;

    localparam int NUM_CHN = 8;
    localparam int DECIM   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din_dr = '0, din_di = '0;
    logic        din_dv = 1'b0;
    logic [7:0]  din_chn = '0;
    logic        sync_in = 1'b0;
    logic [15:0] dout_dr, dout_di;
    logic        dout_dv;
    logic [7:0]  dout_chn;
    logic        sync_out, err_chn;

    prach_decim_acc #(
        .NUM_CHN (NUM_CHN),
        .DECIM   (DECIM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_dr   (din_dr),
        .din_di   (din_di),
        .din_dv   (din_dv),
        .din_chn  (din_chn),
        .sync_in  (sync_in),
        .dout_dr  (dout_dr),
        .dout_di  (dout_di),
        .dout_dv  (dout_dv),
        .dout_chn (dout_chn),
        .sync_out (sync_out),
        .err_chn  (err_chn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dr;
        int di;
        int chn;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   sync_q[$];

    int m_cnt [NUM_CHN];
    int m_sr  [NUM_CHN];
    int m_si  [NUM_CHN];

    int checks = 0;
    int errors = 0;

    // Mean of a block, rounded half toward +infinity.
    function automatic int mean_round(input int s);
        int t, q;
        t = s + DECIM / 2;
        q = t / DECIM;
        if ((t % DECIM) != 0 && t < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NUM_CHN; c++) begin
            m_cnt[c] = 0;
            m_sr[c]  = 0;
            m_si[c]  = 0;
        end
    endtask

    task automatic send(input bit dv, input int chn, input int dr, input int di, input bit sy);
        @(negedge clk);
        din_dv  = dv;
        din_chn = 8'(chn);
        din_dr  = 16'(dr);
        din_di  = 16'(di);
        sync_in = sy;
        if (sy) begin
            sync_q.push_back(cyc + 2);
            for (int c = 0; c < NUM_CHN; c++) m_cnt[c] = 0;
        end
        if (dv) begin
            if (chn >= NUM_CHN) begin
                err_q.push_back(cyc + 1);
            end else begin
                if (m_cnt[chn] == 0) begin
                    m_sr[chn] = dr;
                    m_si[chn] = di;
                end else begin
                    m_sr[chn] += dr;
                    m_si[chn] += di;
                end
                m_cnt[chn]++;
                if (m_cnt[chn] == DECIM) begin
                    exp_q.push_back('{mean_round(m_sr[chn]), mean_round(m_si[chn]), chn, cyc + 2});
                    m_cnt[chn] = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({dout_dr, dout_di, dout_dv, dout_chn, sync_out, err_chn} != '0) begin
            errors++;
            $display("FAIL %s: outputs dr=%0h di=%0h dv=%0b chn=%0d sync=%0b err=%0b, required all 0",
                     name, dout_dr, dout_di, dout_dv, dout_chn, sync_out, err_chn);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        din_dv  = 1'b0;
        sync_in = 1'b0;
        exp_q.delete();
        err_q.delete();
        sync_q.delete();
        model_clear();
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (dout_dv) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dout_unexpected: cyc=%0d dr=%0d chn=%0d, required no output",
                         cyc, $signed(dout_dr), dout_chn);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'($signed(dout_dr)) != e.dr || int'($signed(dout_di)) != e.di ||
                    int'(dout_chn) != e.chn || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL dout: got dr=%0d di=%0d chn=%0d cyc=%0d, required dr=%0d di=%0d chn=%0d cyc=%0d",
                             $signed(dout_dr), $signed(dout_di), dout_chn, cyc, e.dr, e.di, e.chn, e.cyc);
                end
            end
        end
        if (err_chn) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL err_unexpected: err_chn=1 at cyc=%0d, required 0", cyc);
            end else begin
                int ec;
                ec = err_q.pop_front();
                if (ec != cyc) begin
                    errors++;
                    $display("FAIL err_timing: err_chn at cyc=%0d, required cyc=%0d", cyc, ec);
                end
            end
        end
        if (sync_out) begin
            checks++;
            if (sync_q.size() == 0) begin
                errors++;
                $display("FAIL sync_unexpected: sync_out=1 at cyc=%0d, required 0", cyc);
            end else begin
                int sc;
                sc = sync_q.pop_front();
                if (sc != cyc) begin
                    errors++;
                    $display("FAIL sync_timing: sync_out at cyc=%0d, required cyc=%0d", cyc, sc);
                end
            end
        end
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("initial_reset");
        rst_n = 1'b1;

        // Basic block on ch0
        for (int k = 1; k <= 4; k++) send(1'b1, 0, 100 * k, -4 * k, 1'b0);
        idle(3);

        // Rounding corners
        send(1'b1, 0, 1, 0, 1'b0);  send(1'b1, 0, 1, 0, 1'b0);
        send(1'b1, 0, 1, 0, 1'b0);  send(1'b1, 0, 2, 0, 1'b0);
        send(1'b1, 0, -1, 0, 1'b0); send(1'b1, 0, -1, 0, 1'b0);
        send(1'b1, 0, -1, 0, 1'b0); send(1'b1, 0, -2, 0, 1'b0);
        send(1'b1, 0, 1, 1, 1'b0);  send(1'b1, 0, 0, 0, 1'b0);
        send(1'b1, 0, 0, 0, 1'b0);  send(1'b1, 0, 1, 1, 1'b0);
        send(1'b1, 0, -1, -1, 1'b0); send(1'b1, 0, 0, 0, 1'b0);
        send(1'b1, 0, 0, 0, 1'b0);  send(1'b1, 0, -1, -1, 1'b0);
        idle(3);

        // Extremes, interleaved channels
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 0, 32767, -32768, 1'b0);
            send(1'b1, 1, -32768, 32767, 1'b0);
        end
        idle(3);

        // Sync mid-block
        send(1'b1, 0, 1000, 1000, 1'b0);
        send(1'b1, 0, 1000, 1000, 1'b0);
        send(1'b1, 0, 10, -10, 1'b1);
        for (int k = 0; k < 3; k++) send(1'b1, 0, 10, -10, 1'b0);
        idle(3);

        // Out-of-range channel leaves state untouched
        send(1'b1, 8, 5000, 5000, 1'b0);
        for (int k = 0; k < 4; k++) send(1'b1, 0, 0, 0, 1'b0);
        idle(4);

        // Reset mid-block
        for (int k = 0; k < 3; k++) send(1'b1, 2, 50, 50, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) send(1'b1, 2, 7, 7, 1'b0);
        idle(3);

        // Random TDM traffic
        for (int n = 0; n < 3000; n++) begin
            send($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, NUM_CHN + 1)),
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 63) == 0);
        end
        idle(8);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL dout_missing: %0d outputs outstanding, required 0", exp_q.size());
        end
        checks++;
        if (err_q.size() != 0) begin
            errors++;
            $display("FAIL err_missing: %0d err pulses outstanding, required 0", err_q.size());
        end
        checks++;
        if (sync_q.size() != 0) begin
            errors++;
            $display("FAIL sync_missing: %0d sync pulses outstanding, required 0", sync_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
